uart_mmio_ctrl: RTL and testbench
=================================

Name: uart_mmio_ctrl

Overview:
Memory-mapped controller between the CPU data-memory port and the on-chip `uart` ready/valid interface. It decodes the 0x8000_00xx MMIO window, buffers traffic in both directions with small FIFOs, and exposes status, control and byte counters. Firmware such as the echo program polls status, pops RX bytes and pushes TX bytes through it.

Parameters:
FIFO_DEPTH, 8, entries per RX and TX FIFO; power of 2, ≥2
CNT_W, 16, width of each RX/TX byte counter; ≤16

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
mmio_sel  input  1  access targets 0x8000_00xx window (decoded upstream)
mmio_addr  input  5  byte offset within window; [1:0] ignored
mmio_ren  input  1  read strobe, one cycle per access
mmio_wen  input  1  write strobe, one cycle per access
mmio_wdata  input  32  write data
mmio_rdata  output  32  read data, registered
uart_tx_data  output  8  byte to on-chip UART transmitter
uart_tx_valid  output  1  TX byte valid
uart_tx_ready  input  1  transmitter can accept
uart_rx_data  input  8  byte from on-chip UART receiver
uart_rx_valid  input  1  RX byte valid
uart_rx_ready  output  1  controller accepts RX byte
irq  output  1  registered RX interrupt

Behaviour:
- Reset (async): both FIFOs empty, sticky bits 0, control 0, counters 0, mmio_rdata=0, irq=0, uart_tx_valid=0.
- Register map, accesses only when mmio_sel=1:
  - 0x00 STATUS (RO): bit0 tx_not_full; bit1 rx_not_empty; bit2 rx_overrun (sticky); bit3 tx_drop (sticky).
  - 0x04 RXDATA (RO): {24'b0, RX head}. Reading pops the RX FIFO. If the FIFO is empty, returns 0 and does not pop.
  - 0x08 TXDATA (WO): pushes wdata[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_drop is set.
  - 0x0C CONTROL (RW): bit0 write-1 clears both sticky bits and reads 0; bit1 rx_irq_en; bit2 loopback (see Optional Feature).
  - 0x10 COUNT (RO): [15:0] rx_count, [31:16] tx_count. Each counter increments per byte and wraps modulo 2^CNT_W. A write of any value clears both counters.
- Offsets 0x14–0x1C: reads return 0; writes are ignored.
- Read latency: mmio_rdata is valid on the cycle after mmio_ren. STATUS and COUNT reflect pre-edge state. Between reads, mmio_rdata holds its last value.
- Simultaneous ren and wen: the write is performed and the read is ignored.
- TX drain:
  - uart_tx_valid = TX FIFO non-empty; uart_tx_data = TX head.
  - Pop on valid & ready; tx_count increments on pop.
  - The head is stable while valid=1 and ready=0.
- RX fill:
  - uart_rx_ready is constant 1 after reset.
  - On uart_rx_valid, the byte is pushed and rx_count increments.
  - If the FIFO is full, the byte is discarded, rx_overrun is set, and rx_count does not increment.
- Full/empty use pre-edge occupancy:
  - A push to a full FIFO is rejected even if a pop occurs the same cycle.
  - A pop from an empty FIFO is rejected even if a push occurs the same cycle.
  - Push and pop on a partially filled FIFO both succeed; occupancy is unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits equal.
- irq is registered: rx_irq_en & rx_not_empty, updated every cycle.
- Reset asserted mid-transfer immediately empties the FIFOs. uart_tx_valid drops asynchronously; the UART's own reset handles the in-flight frame.

Optional Feature:
UART_MMIO_LOOPBACK_EN
- Defined: CONTROL bit2 is implemented.
  - When set, the TX FIFO head feeds the RX FIFO push path internally. uart_tx_valid is forced to 0, external RX bytes are discarded without setting overrun, and both counters increment per looped byte.
  - A looped byte pops from TX only when RX is not full.
- Not defined: bit2 reads 0, writes to it are ignored, and no loopback logic is present.

Test Plan:
- Reset, then read 0x00 → 0x0000_0001; read 0x10 → 0.
- Off-chip UART sends 0x7A; poll 0x00 until bit1=1; read 0x04 → 0x7A; write 0x08=0x7A → off-chip UART receives 0x7A; 0x10 reads 0x0001_0001.
- With uart_tx_ready held 0, write bytes 0x01..0x09 → first 8 queued, 9th dropped, STATUS=0x8; release ready → 0x01..0x08 emitted in order; write 0x0C=1 → STATUS=0x1.
- Inject 9 RX bytes 0x10..0x18 with no reads → STATUS bit2=1; 8 reads return 0x10..0x17; 9th read returns 0 with no pop.
- Set rx_irq_en, inject 0x55 → irq=1 one cycle after the push; read 0x04 → irq=0 the cycle after the pop.
- With UART_MMIO_LOOPBACK_EN: set CONTROL=0x4, write 0x08=0xA5 → uart_tx_valid stays 0; 0x04 reads 0xA5.

Source files
------------

// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge between the CPU data port and the on-chip UART ready/valid interface.
// Optional internal TX->RX loopback is built only when UART_MMIO_LOOPBACK_EN is defined.
module uart_mmio_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_sel,
  input  logic [4:0]  mmio_addr,
  input  logic        mmio_ren,
  input  logic        mmio_wen,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
    return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  endfunction

  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic             tx_drop_q, tx_drop_d, rx_ovr_q, rx_ovr_d;
  logic             irq_en_q, irq_en_d, irq_q, irq_d, rx_ready_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             loop_on;

  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       wr_en, rd_en;
  logic [2:0] reg_idx;
  logic [7:0] tx_head, rx_head;
  logic       tx_push, tx_pop, tx_drop_evt;
  logic       rx_in_valid, rx_push, rx_pop, rx_ovr_evt;
  logic [7:0] rx_in_data;
  logic       ctrl_wr, cnt_clr;
  logic [15:0] rx_cnt16, tx_cnt16;
  logic       unused_bits;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign tx_full  = ptr_full(tx_wp_q, tx_rp_q);
  assign rx_full  = ptr_full(rx_wp_q, rx_rp_q);
  assign tx_head  = tx_mem_q[tx_rp_q[AW-1:0]];
  assign rx_head  = rx_mem_q[rx_rp_q[AW-1:0]];
  assign wr_en    = mmio_sel & mmio_wen;
  assign rd_en    = mmio_sel & mmio_ren & ~mmio_wen;
  assign reg_idx  = mmio_addr[4:2];
  assign rx_cnt16 = 16'(rx_cnt_q);
  assign tx_cnt16 = 16'(tx_cnt_q);
  assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

`ifdef UART_MMIO_LOOPBACK_EN
  logic loop_q, loop_d;
  assign loop_on = loop_q;
`else
  assign loop_on = 1'b0;
`endif

  assign uart_tx_data  = tx_head;
  assign uart_tx_valid = ~tx_empty & ~loop_on;
  assign uart_rx_ready = rx_ready_q;
  assign mmio_rdata    = rdata_q;
  assign irq           = irq_q;

  // Next-state logic for FIFOs, sticky flags, control, counters and read data.
  always_comb begin
    ctrl_wr     = wr_en && (reg_idx == 3'd3);
    cnt_clr     = wr_en && (reg_idx == 3'd4);
    tx_push     = wr_en && (reg_idx == 3'd2) && !tx_full;
    tx_drop_evt = wr_en && (reg_idx == 3'd2) && tx_full;
`ifdef UART_MMIO_LOOPBACK_EN
    // A looped byte only leaves TX once RX has room, so loopback never overruns.
    if (loop_q) begin
      tx_pop      = !tx_empty && !rx_full;
      rx_in_valid = tx_pop;
      rx_in_data  = tx_head;
    end else begin
      tx_pop      = !tx_empty && uart_tx_ready;
      rx_in_valid = uart_rx_valid && rx_ready_q;
      rx_in_data  = uart_rx_data;
    end
    loop_d = ctrl_wr ? mmio_wdata[2] : loop_q;
`else
    tx_pop      = !tx_empty && uart_tx_ready;
    rx_in_valid = uart_rx_valid && rx_ready_q;
    rx_in_data  = uart_rx_data;
`endif
    rx_push    = rx_in_valid && !rx_full;
    rx_ovr_evt = rx_in_valid && rx_full;
    rx_pop     = rd_en && (reg_idx == 3'd1) && !rx_empty;

    tx_wp_d = tx_push ? tx_wp_q + PW'(1) : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + PW'(1) : tx_rp_q;
    rx_wp_d = rx_push ? rx_wp_q + PW'(1) : rx_wp_q;
    rx_rp_d = rx_pop  ? rx_rp_q + PW'(1) : rx_rp_q;

    // A same-cycle event wins over a clear so no error is silently lost.
    tx_drop_d = tx_drop_evt ? 1'b1 : ((ctrl_wr && mmio_wdata[0]) ? 1'b0 : tx_drop_q);
    rx_ovr_d  = rx_ovr_evt  ? 1'b1 : ((ctrl_wr && mmio_wdata[0]) ? 1'b0 : rx_ovr_q);
    irq_en_d  = ctrl_wr ? mmio_wdata[1] : irq_en_q;

    if (cnt_clr) begin
      rx_cnt_d = '0;
      tx_cnt_d = '0;
    end else begin
      rx_cnt_d = rx_push ? rx_cnt_q + CNT_W'(1) : rx_cnt_q;
      tx_cnt_d = tx_pop  ? tx_cnt_q + CNT_W'(1) : tx_cnt_q;
    end

    irq_d = irq_en_q && !rx_empty;

    rdata_d = rdata_q;
    if (rd_en) begin
      case (reg_idx)
        3'd0:    rdata_d = {28'd0, tx_drop_q, rx_ovr_q, !rx_empty, !tx_full};
        3'd1:    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
        3'd3:    rdata_d = {29'd0, loop_on, irq_en_q, 1'b0};
        3'd4:    rdata_d = {tx_cnt16, rx_cnt16};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // FIFO storage: contents need no reset because pointers gate every read.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= mmio_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_in_data;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      tx_drop_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      rdata_q    <= 32'd0;
`ifdef UART_MMIO_LOOPBACK_EN
      loop_q     <= 1'b0;
`endif
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_drop_q  <= tx_drop_d;
      rx_ovr_q   <= rx_ovr_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rx_ready_q <= 1'b1;
      rdata_q    <= rdata_d;
`ifdef UART_MMIO_LOOPBACK_EN
      loop_q     <= loop_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: queued expectations for MMIO reads and TX bytes.
// Loopback checks are compiled when UART_MMIO_LOOPBACK_EN is defined.
module tb_uart_mmio_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mmio_sel = 1'b0, mmio_ren = 1'b0, mmio_wen = 1'b0;
  logic [4:0]  mmio_addr = 5'd0;
  logic [31:0] mmio_wdata = 32'd0;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b1;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  uart_mmio_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .mmio_sel(mmio_sel), .mmio_addr(mmio_addr), .mmio_ren(mmio_ren), .mmio_wen(mmio_wen),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // TX side of the scoreboard: every accepted byte must match the oldest queued one.
  always @(negedge clk) begin
    if (!reset && uart_tx_valid && uart_tx_ready) begin
      if (tx_exp_q.size() == 0) check("tx_unexpected", {24'd0, uart_tx_data}, 32'hFFFF_FFFF);
      else check("tx_byte", {24'd0, uart_tx_data}, {24'd0, tx_exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [4:0] a, input logic [31:0] d);
    mmio_sel = 1'b1; mmio_wen = 1'b1; mmio_addr = a; mmio_wdata = d;
    tick();
    mmio_sel = 1'b0; mmio_wen = 1'b0;
  endtask

  task automatic mmio_read_raw(input logic [4:0] a, output logic [31:0] d);
    mmio_sel = 1'b1; mmio_ren = 1'b1; mmio_addr = a;
    tick();
    mmio_sel = 1'b0; mmio_ren = 1'b0;
    d = mmio_rdata;
  endtask

  task automatic mmio_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd_exp_q.push_back(exp);
    mmio_read_raw(a, d);
    check(tag, d, rd_exp_q.pop_front());
  endtask

  task automatic rx_inject(input logic [7:0] b);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 50 && tx_exp_q.size() != 0; i++) tick();
    tick();
    check("tx_drain_done", tx_exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        seen;

    repeat (2) tick();
    check("reset_rdata", mmio_rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("rx_ready", {31'd0, uart_rx_ready}, 32'd1);
    mmio_read("status_reset", 5'h00, 32'h0000_0001);
    mmio_read("count_reset", 5'h10, 32'h0000_0000);

    // Echo one byte.
    rx_inject(8'h7A);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      mmio_read_raw(5'h00, d);
      seen = d[1];
    end
    check("rx_poll_seen", {31'd0, seen}, 32'd1);
    mmio_read("echo_rx", 5'h04, 32'h0000_007A);
    tx_exp_q.push_back(8'h7A);
    mmio_write(5'h08, 32'h0000_007A);
    wait_tx_drain();
    mmio_read("echo_count", 5'h10, 32'h0001_0001);

    // TX overflow with the transmitter stalled.
    uart_tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_exp_q.push_back(8'(i));
      mmio_write(5'h08, 32'(i));
    end
    mmio_read("status_tx_drop", 5'h00, 32'h0000_0008);
    repeat (2) tick();
    check("tx_head_stable", {23'd0, uart_tx_valid, uart_tx_data}, 32'h0000_0101);
    uart_tx_ready = 1'b1;
    wait_tx_drain();
    mmio_write(5'h0C, 32'h0000_0001);
    mmio_read("status_cleared", 5'h00, 32'h0000_0001);
    mmio_read("count_after_tx", 5'h10, 32'h0009_0001);
    mmio_write(5'h10, 32'hDEAD_BEEF);
    mmio_read("count_clear", 5'h10, 32'h0000_0000);

    // RX overrun: nine bytes into an eight-entry FIFO.
    for (int i = 0; i < 9; i++) rx_inject(8'h10 + 8'(i));
    mmio_read("status_overrun", 5'h00, 32'h0000_0007);
    for (int i = 0; i < 8; i++) mmio_read("rx_drain", 5'h04, 32'h10 + 32'(i));
    mmio_read("rx_empty_read", 5'h04, 32'h0000_0000);
    mmio_read("status_after_drain", 5'h00, 32'h0000_0005);
    mmio_read("count_rx8", 5'h10, 32'h0000_0008);

    // Interrupt timing.
    mmio_write(5'h0C, 32'h0000_0002);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h55;
    tick();
    uart_rx_valid = 1'b0;
    check("irq_push_edge", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    mmio_read("irq_rx", 5'h04, 32'h0000_0055);
    check("irq_pop_edge", {31'd0, irq}, 32'd1);
    tick();
    check("irq_clear", {31'd0, irq}, 32'd0);

    // Simultaneous read/write: write wins, rdata holds.
    mmio_sel = 1'b1; mmio_ren = 1'b1; mmio_wen = 1'b1; mmio_addr = 5'h10; mmio_wdata = 32'd0;
    tick();
    mmio_sel = 1'b0; mmio_ren = 1'b0; mmio_wen = 1'b0;
    check("rw_hold", mmio_rdata, 32'h0000_0055);
    mmio_read("rw_count_cleared", 5'h10, 32'h0000_0000);
    mmio_write(5'h1C, 32'hFFFF_FFFF);
    mmio_read("reserved_read", 5'h14, 32'h0000_0000);
    mmio_read("control_read", 5'h0C, 32'h0000_0002);
    mmio_read("status_sticky", 5'h00, 32'h0000_0005);
    mmio_write(5'h0C, 32'h0000_0001);
    mmio_read("status_clear2", 5'h00, 32'h0000_0001);

`ifdef UART_MMIO_LOOPBACK_EN
    mmio_write(5'h0C, 32'h0000_0004);
    mmio_read("loop_ctrl", 5'h0C, 32'h0000_0004);
    mmio_write(5'h08, 32'h0000_00A5);
    for (int i = 0; i < 4; i++) begin
      check("loop_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
      tick();
    end
    mmio_read("loop_rx", 5'h04, 32'h0000_00A5);
    mmio_read("loop_count", 5'h10, 32'h0001_0001);
`else
    mmio_write(5'h0C, 32'h0000_0004);
    mmio_read("noloop_ctrl", 5'h0C, 32'h0000_0000);
`endif
    mmio_write(5'h0C, 32'h0000_0000);

    // Reset mid-transfer drops tx_valid immediately.
    uart_tx_ready = 1'b0;
    mmio_write(5'h08, 32'h0000_0033);
    check("pre_reset_valid", {31'd0, uart_tx_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_valid", {31'd0, uart_tx_valid}, 32'd0);
    tick();
    reset = 1'b0;
    uart_tx_ready = 1'b1;
    repeat (3) tick();
    check("tx_queue_empty", tx_exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
